snoop_cache_node: RTL

- Parametrised snooping MESI cache node: one direct-mapped, write-back cache per processor on the shared snoop bus.
- Accepts processor load/store requests over a valid/ready handshake and arbitrates for the bus.
- Fetches lines, writes back Modified victims, and answers snoops from other nodes with shared/flush responses.
- MESI next-state logic is internal. Generalises the earlier fixed 4-line, 3-bit-tag, 3-bit-data node with configurable geometry, eviction write-back and snoop flush.

---
 rtl/snoop_cache_node.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/snoop_cache_node.sv
// Snooping MESI cache node: direct-mapped, write-back, one word per line.
// Serves load/store requests, fetches/evicts lines over the shared bus and answers snoops.
module snoop_cache_node #(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 3,
  localparam int IDX_W    = $clog2(NUM_LINES),
  localparam int ADDR_W   = TAG_W + IDX_W
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_data,
  output logic              cpu_resp_hit,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [1:0]        bus_cmd_out,
  output logic [ADDR_W-1:0] bus_addr_out,
  output logic [DATA_W-1:0] bus_data_out,
  input  logic [1:0]        bus_cmd_in,
  input  logic [ADDR_W-1:0] bus_addr_in,
  input  logic              shared_in,
  input  logic              flush_in,
  input  logic [DATA_W-1:0] bus_data_in,
  input  logic              mem_ack,
  output logic              shared_out,
  output logic              flush_out
);

  typedef enum logic [1:0] {LS_I = 2'd0, LS_S = 2'd1, LS_E = 2'd2, LS_M = 2'd3} line_state_e;
  typedef enum logic [1:0] {CMD_NONE = 2'd0, CMD_BUSRD = 2'd1, CMD_BUSRDX = 2'd2, CMD_FLUSH = 2'd3} bus_cmd_e;
  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_ARB, ST_WB, ST_ISSUE, ST_FILL, ST_RESP} fsm_e;

  fsm_e fsm_q, fsm_d;

  line_state_e       state_q [NUM_LINES];
  logic [TAG_W-1:0]  tag_q   [NUM_LINES];
  logic [DATA_W-1:0] data_q  [NUM_LINES];

  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_hit_q;
  logic              fill_first_q;
  logic              shared_seen_q;
  logic              shared_q;
  logic              flush_q;
  logic [DATA_W-1:0] flush_data_q;

  logic [IDX_W-1:0] req_idx, snp_idx;
  logic [TAG_W-1:0] req_tag, snp_tag;
  logic             snp_hit;
  line_state_e      snp_new;
  line_state_e      cur_state;
  logic             hit, store_hit, lookup_done, victim_dirty, fill_shared;

  assign req_idx = req_addr_q[IDX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:IDX_W];
  assign snp_idx = bus_addr_in[IDX_W-1:0];
  assign snp_tag = bus_addr_in[ADDR_W-1:IDX_W];

  // Snooping is suspended only while this node itself owns the command bus.
  assign snp_hit = (fsm_q != ST_WB) && (fsm_q != ST_ISSUE) &&
                   ((bus_cmd_in == CMD_BUSRD) || (bus_cmd_in == CMD_BUSRDX)) &&
                   (tag_q[snp_idx] == snp_tag) && (state_q[snp_idx] != LS_I);
  assign snp_new = (bus_cmd_in == CMD_BUSRDX) ? LS_I : LS_S;

  // Local decisions see the line as it will be after this cycle's snoop.
  assign cur_state    = (snp_hit && (snp_idx == req_idx)) ? snp_new : state_q[req_idx];
  assign hit          = (tag_q[req_idx] == req_tag) && (cur_state != LS_I);
  assign store_hit    = hit && req_write_q && ((cur_state == LS_E) || (cur_state == LS_M));
  assign lookup_done  = hit && (!req_write_q || store_hit);
  assign victim_dirty = !hit && (cur_state == LS_M);
  // A flushing owner keeps a shared copy, so its flush also counts as a sharer.
  assign fill_shared  = fill_first_q ? (shared_in | flush_in) : shared_seen_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    fsm_d          = fsm_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_data  = '0;
    cpu_resp_hit   = 1'b0;
    bus_req        = 1'b0;
    bus_cmd_out    = CMD_NONE;
    bus_addr_out   = '0;
    bus_data_out   = flush_q ? flush_data_q : '0;
    unique case (fsm_q)
      ST_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) fsm_d = ST_LOOKUP;
      end
      ST_LOOKUP: fsm_d = lookup_done ? ST_RESP : ST_ARB;
      ST_ARB: begin
        bus_req = 1'b1;
        if (bus_grant) fsm_d = victim_dirty ? ST_WB : ST_ISSUE;
      end
      ST_WB: begin
        bus_req      = 1'b1;
        bus_cmd_out  = CMD_FLUSH;
        bus_addr_out = {tag_q[req_idx], req_idx};
        bus_data_out = data_q[req_idx];
        fsm_d        = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus_req      = 1'b1;
        bus_cmd_out  = req_write_q ? CMD_BUSRDX : CMD_BUSRD;
        bus_addr_out = req_addr_q;
        fsm_d        = ST_FILL;
      end
      ST_FILL: begin
        bus_req = 1'b1;
        if (mem_ack) fsm_d = ST_RESP;
      end
      ST_RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_data  = resp_data_q;
        cpu_resp_hit   = resp_hit_q;
        fsm_d          = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      fsm_q         <= ST_IDLE;
      req_write_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      resp_data_q   <= '0;
      resp_hit_q    <= 1'b0;
      fill_first_q  <= 1'b0;
      shared_seen_q <= 1'b0;
      shared_q      <= 1'b0;
      flush_q       <= 1'b0;
      flush_data_q  <= '0;
    end else begin
      fsm_q        <= fsm_d;
      fill_first_q <= (fsm_q == ST_ISSUE);
      shared_q     <= snp_hit;
      flush_q      <= snp_hit && (state_q[snp_idx] == LS_M);
      flush_data_q <= data_q[snp_idx];
      if (fill_first_q) shared_seen_q <= shared_in | flush_in;
      if ((fsm_q == ST_IDLE) && cpu_req_valid) begin
        req_write_q <= cpu_req_write;
        req_addr_q  <= cpu_req_addr;
        req_wdata_q <= cpu_req_wdata;
      end
      if (fsm_q == ST_LOOKUP) begin
        resp_hit_q  <= 1'b1;
        resp_data_q <= req_write_q ? req_wdata_q : data_q[req_idx];
      end
      if ((fsm_q == ST_FILL) && mem_ack) begin
        resp_hit_q  <= 1'b0;
        resp_data_q <= req_write_q ? req_wdata_q : bus_data_in;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      // NOTE: the line array is small and must come up Invalid, so it is reset like any register.
      for (int i = 0; i < NUM_LINES; i++) begin
        state_q[i] <= LS_I;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking updates; a local update below overrides the snoop update to the same line.
      if (snp_hit) state_q[snp_idx] <= snp_new;
      unique case (fsm_q)
        ST_LOOKUP: if (store_hit) begin
          state_q[req_idx] <= LS_M;
          data_q[req_idx]  <= req_wdata_q;
        end
        ST_WB: state_q[req_idx] <= LS_I;
        ST_FILL: if (mem_ack) begin
          tag_q[req_idx]   <= req_tag;
          state_q[req_idx] <= req_write_q ? LS_M : (fill_shared ? LS_S : LS_E);
          data_q[req_idx]  <= req_write_q ? req_wdata_q : bus_data_in;
        end
        default: ;
      endcase
    end
  end

  assign shared_out = shared_q;
  assign flush_out  = flush_q;

endmodule
